flu_wb_scheduler: RTL and testbench



---
 rtl/flu_wb_scheduler_pkg.sv | 22 ++
 rtl/flu_wb_scheduler_if.sv | 37 +++
 rtl/flu_wb_scheduler_wb_slot_shreg.sv | 51 +++++
 rtl/flu_wb_scheduler.sv | 141 ++++++++++++++
 tb/tb_flu_wb_scheduler.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/flu_wb_scheduler_pkg.sv
// Shared FLU write-back scheduling types and constants.
// Used by the scheduler, its interface and the slot shift register.
package flu_wb_scheduler_pkg;

  localparam int unsigned FLU_MAX_LAT       = 4;
  localparam int unsigned FLU_TRANS_ID_BITS = 3;

  // Width of a latency field able to encode 0..max_lat.
  function automatic int unsigned lat_width(input int unsigned max_lat);
    return (max_lat < 1) ? 1 : $clog2(max_lat + 1);
  endfunction

  localparam int unsigned FLU_LAT_W = lat_width(FLU_MAX_LAT);

  typedef logic [FLU_LAT_W-1:0] flu_lat_t;

  typedef struct packed {
    logic                         valid;
    logic [FLU_TRANS_ID_BITS-1:0] trans_id;
  } flu_slot_t;

endpackage

// File: rtl/flu_wb_scheduler_if.sv
// Issue/write-back bundle between FLU issue logic and the write-back slot scheduler.
// The slave modport is the scheduler side; master is the issue-logic side.
interface flu_wb_scheduler_if
  import flu_wb_scheduler_pkg::*;
#(
  parameter int unsigned MAX_LAT       = FLU_MAX_LAT,
  parameter int unsigned TRANS_ID_BITS = FLU_TRANS_ID_BITS
);

  localparam int unsigned LAT_W = lat_width(MAX_LAT);

  logic                     clr_i;
  logic                     flush_i;
  logic                     issue_valid_i;
  logic [LAT_W-1:0]         issue_lat_i;
  logic                     issue_var_i;
  logic [TRANS_ID_BITS-1:0] issue_trans_id_i;
  logic                     issue_ready_o;
  logic                     var_done_i;
  logic                     wb_valid_o;
  logic [TRANS_ID_BITS-1:0] wb_trans_id_o;
  logic                     busy_o;
  logic [31:0]              stall_cnt_o;

  modport slave (
    input  clr_i, flush_i, issue_valid_i, issue_lat_i, issue_var_i,
           issue_trans_id_i, var_done_i,
    output issue_ready_o, wb_valid_o, wb_trans_id_o, busy_o, stall_cnt_o
  );

  modport master (
    output clr_i, flush_i, issue_valid_i, issue_lat_i, issue_var_i,
           issue_trans_id_i, var_done_i,
    input  issue_ready_o, wb_valid_o, wb_trans_id_o, busy_o, stall_cnt_o
  );

endinterface

// File: rtl/flu_wb_scheduler_wb_slot_shreg.sv
// Occupancy/id shift register for the FLU write-back port: slot k owns the port k cycles ahead.
// A reservation for latency L lands in slot L-1 of the next state; the top slot is always free.
module wb_slot_shreg
  import flu_wb_scheduler_pkg::*;
#(
  parameter int unsigned MAX_LAT       = FLU_MAX_LAT,
  parameter int unsigned TRANS_ID_BITS = FLU_TRANS_ID_BITS,
  parameter int unsigned LAT_W         = lat_width(MAX_LAT)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  clr_i,
  input  logic                                  rsv_i,
  input  logic [LAT_W-1:0]                      rsv_idx_i,
  input  logic [TRANS_ID_BITS-1:0]              rsv_tid_i,
  output logic [MAX_LAT:0]                      occ_o,
  output logic [MAX_LAT:0][TRANS_ID_BITS-1:0]   tid_o
);

  logic [MAX_LAT-1:0]                      occ_q, occ_d;
  logic [MAX_LAT-1:0][TRANS_ID_BITS-1:0]   tid_q, tid_d;

  assign occ_o = {1'b0, occ_q};
  assign tid_o = {{TRANS_ID_BITS{1'b0}}, tid_q};

  always_comb begin
    occ_d = '0;
    tid_d = '0;
    if (!clr_i) begin
      for (int k = 0; k < int'(MAX_LAT); k++) begin
        occ_d[k] = occ_o[k+1];
        tid_d[k] = tid_o[k+1];
        if (rsv_i && (int'(rsv_idx_i) == k + 1)) begin
          occ_d[k] = 1'b1;
          tid_d[k] = rsv_tid_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occ_q <= '0;
      tid_q <= '0;
    end else begin
      occ_q <= occ_d;
      tid_q <= tid_d;
    end
  end

endmodule

// File: rtl/flu_wb_scheduler.sv
// FLU write-back slot scheduler: reserves the shared result port at issue and serialises divides.
// Optional stall counter enabled by defining FLU_WB_SCHED_PERF_EN.
module flu_wb_scheduler
  import flu_wb_scheduler_pkg::*;
#(
  parameter int unsigned MAX_LAT       = FLU_MAX_LAT,
  parameter int unsigned TRANS_ID_BITS = FLU_TRANS_ID_BITS
) (
  input logic               clk_i,
  input logic               rst_i,
  flu_wb_scheduler_if.slave bus
);

  localparam int unsigned LAT_W = lat_width(MAX_LAT);

  logic [MAX_LAT:0]                    occ;
  logic [MAX_LAT:0][TRANS_ID_BITS-1:0] tid;

  logic                     lat_ok, slot_free, blocked, ready;
  logic                     grant, fixed_grant, var_grant, rsv, sched_clr, var_fire;
  logic                     var_busy_q, var_busy_d;
  logic [TRANS_ID_BITS-1:0] var_tid_q, var_tid_d;

  // Readiness never looks at issue_valid_i so issue logic can query it combinationally.
  always_comb begin
    lat_ok    = int'(bus.issue_lat_i) <= int'(MAX_LAT);
    slot_free = 1'b0;
    if (bus.issue_var_i) begin
      slot_free = (occ[MAX_LAT:1] == '0);
    end else if (lat_ok) begin
      slot_free = !occ[bus.issue_lat_i];
    end
    blocked = bus.flush_i | bus.clr_i | var_busy_q | bus.var_done_i;
    ready   = !blocked && slot_free;
  end

  assign bus.issue_ready_o = ready;
  assign grant       = bus.issue_valid_i & ready;
  assign fixed_grant = grant & !bus.issue_var_i;
  assign var_grant   = grant & bus.issue_var_i;
  assign rsv         = fixed_grant & (bus.issue_lat_i != '0);
  assign sched_clr   = bus.clr_i | bus.flush_i;
  assign var_fire    = bus.var_done_i & var_busy_q;

  wb_slot_shreg #(
    .MAX_LAT       (MAX_LAT),
    .TRANS_ID_BITS (TRANS_ID_BITS),
    .LAT_W         (LAT_W)
  ) u_slots (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (sched_clr),
    .rsv_i     (rsv),
    .rsv_idx_i (bus.issue_lat_i),
    .rsv_tid_i (bus.issue_trans_id_i),
    .occ_o     (occ),
    .tid_o     (tid)
  );

  always_comb begin
    var_busy_d = var_busy_q;
    var_tid_d  = var_tid_q;
    if (bus.clr_i) begin
      var_busy_d = 1'b0;
      var_tid_d  = '0;
    end else if (bus.flush_i) begin
      var_busy_d = 1'b0;
    end else if (var_grant) begin
      var_busy_d = 1'b1;
      var_tid_d  = bus.issue_trans_id_i;
    end else if (var_fire) begin
      var_busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      var_busy_q <= 1'b0;
      var_tid_q  <= '0;
    end else begin
      var_busy_q <= var_busy_d;
      var_tid_q  <= var_tid_d;
    end
  end

  assign bus.busy_o = var_busy_q;

  // The slot check guarantees at most one of these sources is active; the order is a safety net.
  always_comb begin
    bus.wb_valid_o    = 1'b0;
    bus.wb_trans_id_o = '0;
    if (var_fire) begin
      bus.wb_valid_o    = 1'b1;
      bus.wb_trans_id_o = var_tid_q;
    end else if (occ[0]) begin
      bus.wb_valid_o    = 1'b1;
      bus.wb_trans_id_o = tid[0];
    end else if (fixed_grant && (bus.issue_lat_i == '0)) begin
      bus.wb_valid_o    = 1'b1;
      bus.wb_trans_id_o = bus.issue_trans_id_i;
    end
  end

`ifdef FLU_WB_SCHED_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        stall_evt;

  always_comb begin
    stall_evt   = bus.issue_valid_i & !ready & !bus.flush_i;
    stall_cnt_d = stall_cnt_q;
    if (bus.clr_i) begin
      stall_cnt_d = '0;
    end else if (stall_evt && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_cnt_o = stall_cnt_q;
`else
  assign bus.stall_cnt_o = '0;
`endif

`ifndef SYNTHESIS
  // A completion with nothing outstanding means the divider and issue logic disagree.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(bus.var_done_i && !var_busy_q))
        else $error("var_done_i asserted with no variable-latency op outstanding");
    end
  end
`endif

endmodule

// File: tb/tb_flu_wb_scheduler.sv
// Directed bench for flu_wb_scheduler; expected values are hand-derived per step.
// Stall-counter expectations follow FLU_WB_SCHED_PERF_EN.
module tb_flu_wb_scheduler;
  import flu_wb_scheduler_pkg::*;

`ifdef FLU_WB_SCHED_PERF_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_asrt = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  flu_wb_scheduler_if #(.MAX_LAT(4), .TRANS_ID_BITS(3)) bus ();

  flu_wb_scheduler #(.MAX_LAT(4), .TRANS_ID_BITS(3)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] lat, input logic var_op,
                       input logic [2:0] id);
    bus.issue_valid_i    = v;
    bus.issue_lat_i      = lat;
    bus.issue_var_i      = var_op;
    bus.issue_trans_id_i = id;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.clr_i      = 1'b0;
    bus.flush_i    = 1'b0;
    bus.var_done_i = 1'b0;
    drive(1'b0, 3'd0, 1'b0, 3'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    // Reset state
    chk("rst_wb_valid", 32'(bus.wb_valid_o), 32'd0);
    chk("rst_wb_tid",   32'(bus.wb_trans_id_o), 32'd0);
    chk("rst_busy",     32'(bus.busy_o), 32'd0);
    chk("rst_stall",    bus.stall_cnt_o, 32'd0);
    for (int l = 0; l <= 4; l++) begin
      bus.issue_lat_i = 3'(l);
      #1;
      chk($sformatf("rst_ready_L%0d", l), 32'(bus.issue_ready_o), 32'd1);
    end
    bus.issue_var_i = 1'b1;
    #1;
    chk("rst_ready_var", 32'(bus.issue_ready_o), 32'd1);
    bus.issue_var_i = 1'b0;

    // Fixed L=2, id 5: write-back two cycles later, only there
    tick(); drive(1'b1, 3'd2, 1'b0, 3'd5); #1;
    chk("t1_ready_c0", 32'(bus.issue_ready_o), 32'd1);
    chk("t1_wb_c0",    32'(bus.wb_valid_o), 32'd0);
    tick(); drive(1'b0, 3'd2, 1'b0, 3'd0); #1;
    chk("t1_wb_c1",    32'(bus.wb_valid_o), 32'd0);
    chk("t1_ready_c1", 32'(bus.issue_ready_o), 32'd1);
    tick(); #1;
    chk("t1_wb_c2",    32'(bus.wb_valid_o), 32'd1);
    chk("t1_tid_c2",   32'(bus.wb_trans_id_o), 32'd5);
    chk("t1_ready_c2", 32'(bus.issue_ready_o), 32'd1);
    tick(); #1;
    chk("t1_wb_c3",    32'(bus.wb_valid_o), 32'd0);

    // Slot conflict: L=2 id1 then L=1 id2 refused once, granted next cycle
    tick(); drive(1'b1, 3'd2, 1'b0, 3'd1); #1;
    chk("t2_ready_c0", 32'(bus.issue_ready_o), 32'd1);
    tick(); drive(1'b1, 3'd1, 1'b0, 3'd2); #1;
    chk("t2_ready_c1", 32'(bus.issue_ready_o), 32'd0);
    tick(); #1;
    chk("t2_ready_c2", 32'(bus.issue_ready_o), 32'd1);
    chk("t2_wb_c2",    32'(bus.wb_valid_o), 32'd1);
    chk("t2_tid_c2",   32'(bus.wb_trans_id_o), 32'd1);
    tick(); drive(1'b0, 3'd0, 1'b0, 3'd0); #1;
    chk("t2_wb_c3",    32'(bus.wb_valid_o), 32'd1);
    chk("t2_tid_c3",   32'(bus.wb_trans_id_o), 32'd2);
    chk("t2_stall",    bus.stall_cnt_o, (PERF != 0) ? 32'd1 : 32'd0);

    // Variable-latency op against a pending fixed result
    tick(); drive(1'b1, 3'd2, 1'b0, 3'd2); #1;
    chk("t3_ready_fix", 32'(bus.issue_ready_o), 32'd1);
    tick(); drive(1'b1, 3'd0, 1'b1, 3'd3); #1;
    chk("t3_var_refused", 32'(bus.issue_ready_o), 32'd0);
    chk("t3_wb_c1",       32'(bus.wb_valid_o), 32'd0);
    tick(); #1;
    chk("t3_var_granted", 32'(bus.issue_ready_o), 32'd1);
    chk("t3_wb_c2",       32'(bus.wb_valid_o), 32'd1);
    chk("t3_tid_c2",      32'(bus.wb_trans_id_o), 32'd2);
    tick(); drive(1'b1, 3'd1, 1'b0, 3'd4); #1;
    chk("t3_busy",        32'(bus.busy_o), 32'd1);
    chk("t3_fix_blocked", 32'(bus.issue_ready_o), 32'd0);
    chk("t3_wb_c3",       32'(bus.wb_valid_o), 32'd0);
    bus.issue_var_i = 1'b1; #1;
    chk("t3_var_blocked", 32'(bus.issue_ready_o), 32'd0);
    tick(); drive(1'b1, 3'd0, 1'b0, 3'd6); bus.var_done_i = 1'b1; #1;
    chk("t3_done_l0_refused", 32'(bus.issue_ready_o), 32'd0);
    chk("t3_done_wb",         32'(bus.wb_valid_o), 32'd1);
    chk("t3_done_tid",        32'(bus.wb_trans_id_o), 32'd3);
    chk("t3_done_busy",       32'(bus.busy_o), 32'd1);
    tick(); bus.var_done_i = 1'b0; drive(1'b0, 3'd0, 1'b0, 3'd0); #1;
    chk("t3_busy_fall",  32'(bus.busy_o), 32'd0);
    chk("t3_wb_after",   32'(bus.wb_valid_o), 32'd0);
    chk("t3_ready_l0",   32'(bus.issue_ready_o), 32'd1);
    chk("t3_stall",      bus.stall_cnt_o, (PERF != 0) ? 32'd4 : 32'd0);

    // Flush drops reservations at L=4 (id1) and L=1 (id2)
    tick(); drive(1'b1, 3'd4, 1'b0, 3'd1); #1;
    chk("t4_ready_l4", 32'(bus.issue_ready_o), 32'd1);
    tick(); drive(1'b1, 3'd1, 1'b0, 3'd2); #1;
    chk("t4_ready_l1", 32'(bus.issue_ready_o), 32'd1);
    tick(); drive(1'b1, 3'd1, 1'b0, 3'd3); bus.flush_i = 1'b1; #1;
    chk("t4_flush_ready", 32'(bus.issue_ready_o), 32'd0);
    chk("t4_flush_wb",    32'(bus.wb_valid_o), 32'd1);
    chk("t4_flush_tid",   32'(bus.wb_trans_id_o), 32'd2);
    tick(); bus.flush_i = 1'b0; drive(1'b0, 3'd1, 1'b0, 3'd0); #1;
    chk("t4_post_ready", 32'(bus.issue_ready_o), 32'd1);
    chk("t4_post_wb0",   32'(bus.wb_valid_o), 32'd0);
    for (int i = 1; i < 4; i++) begin
      tick(); #1;
      chk($sformatf("t4_post_wb%0d", i), 32'(bus.wb_valid_o), 32'd0);
    end
    tick(); drive(1'b1, 3'd1, 1'b0, 3'd7); #1;
    chk("t4_regrant", 32'(bus.issue_ready_o), 32'd1);
    tick(); drive(1'b0, 3'd0, 1'b0, 3'd0); #1;
    chk("t4_regrant_wb",  32'(bus.wb_valid_o), 32'd1);
    chk("t4_regrant_tid", 32'(bus.wb_trans_id_o), 32'd7);
    chk("t4_stall",       bus.stall_cnt_o, (PERF != 0) ? 32'd4 : 32'd0);

    // Asynchronous reset mid-cycle while a var op completes
    tick(); drive(1'b1, 3'd0, 1'b1, 3'd5); #1;
    chk("t5_var_ready", 32'(bus.issue_ready_o), 32'd1);
    tick(); drive(1'b0, 3'd0, 1'b0, 3'd0); bus.var_done_i = 1'b1; #1;
    chk("t5_busy",   32'(bus.busy_o), 32'd1);
    chk("t5_wb",     32'(bus.wb_valid_o), 32'd1);
    chk("t5_tid",    32'(bus.wb_trans_id_o), 32'd5);
    #1; rst = 1'b1; #1;
    chk("t5_arst_busy",  32'(bus.busy_o), 32'd0);
    chk("t5_arst_wb",    32'(bus.wb_valid_o), 32'd0);
    chk("t5_arst_tid",   32'(bus.wb_trans_id_o), 32'd0);
    chk("t5_arst_stall", bus.stall_cnt_o, 32'd0);
    bus.var_done_i = 1'b0;
    tick(); rst = 1'b0; bus.issue_var_i = 1'b1; #1;
    chk("t5_ready_var", 32'(bus.issue_ready_o), 32'd1);

`ifdef FLU_WB_SCHED_PERF_EN
    // Counter saturation under a held conflict
    tick(); drive(1'b1, 3'd0, 1'b1, 3'd1); #1;
    chk("t6_var_grant", 32'(bus.issue_ready_o), 32'd1);
    tick(); #1;
    force u_dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release u_dut.stall_cnt_q;
    tick(); tick(); tick(); #1;
    chk("t6_stall_sat", bus.stall_cnt_o, 32'hFFFF_FFFF);
    drive(1'b0, 3'd0, 1'b0, 3'd0); bus.var_done_i = 1'b1;
    tick(); bus.var_done_i = 1'b0; #1;
    chk("t6_busy_clear", 32'(bus.busy_o), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
